// File: rtl/ahb_lite_slave_mem_if.sv
// rtl/ahb_lite_slave_mem_if.sv - AHB-lite bus bundle between one master and one slave
interface ahb_lite_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  hsel;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [3:0]            hprot;
    logic                  hready;
    logic [DATA_WIDTH-1:0] hwdata;
    logic [DATA_WIDTH-1:0] hrdata;
    logic                  hreadyout;
    logic                  hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hready, hwdata,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hready, hwdata,
        output hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/ahb_lite_slave_mem.sv
// rtl/ahb_lite_slave_mem.sv - AHB-lite slave memory with fixed wait states and two-cycle ERROR
module ahb_lite_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input logic                 hclk,
    input logic                 hresetn,
    ahb_lite_slave_mem_if.slave bus
);
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(BYTES);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int WIDX_W = ADDR_WIDTH - LANE_W;
    localparam logic [WIDX_W-1:0] DEPTH_W = WIDX_W'(MEM_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    state_t                state;
    logic [3:0]            wait_cnt;
    logic                  pending;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [2:0]            size_q;

    logic                  accept;
    logic                  sample;
    logic                  addr_err;
    logic [LANE_W-1:0]     align_mask;
    logic [BYTES-1:0]      lane_en;
    logic [IDX_W-1:0]      idx_q;
    logic                  unused_ok;

    // Only states with hreadyout high may take a new address phase.
    assign accept     = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
    assign sample     = accept && bus.hsel && bus.hready && bus.htrans[1];
    assign align_mask = LANE_W'((32'd1 << bus.hsize) - 32'd1);
    assign addr_err   = (bus.haddr[ADDR_WIDTH-1:LANE_W] >= DEPTH_W)
                     || (bus.hsize > 3'(LANE_W))
                     || (|(bus.haddr[LANE_W-1:0] & align_mask));
    assign idx_q      = addr_q[LANE_W +: IDX_W];
    assign unused_ok  = ^{bus.hburst, bus.hprot, bus.htrans[0], addr_q};

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            pending  <= 1'b0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= 3'd0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (wait_cnt == 4'd0) state <= S_DATA;
                    else wait_cnt <= wait_cnt - 4'd1;
                end
                S_ERR1: state <= S_ERR2;
                default: begin
                    if (sample) begin
                        addr_q  <= bus.haddr;
                        write_q <= bus.hwrite;
                        size_q  <= bus.hsize;
                        pending <= 1'b1;
                        if (addr_err) begin
                            state <= S_ERR1;
                        end else if (WAIT_STATES > 0) begin
                            state    <= S_WAIT;
                            wait_cnt <= 4'(WAIT_STATES - 1);
                        end else begin
                            state <= S_DATA;
                        end
                    end else begin
                        state   <= S_IDLE;
                        pending <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        lane_en = '0;
        for (int i = 0; i < BYTES; i++) begin
            lane_en[i] = (i >= int'(addr_q[LANE_W-1:0]))
                      && (i < int'(addr_q[LANE_W-1:0]) + (1 << size_q));
        end
    end

    // The write lands on the edge closing DATA, so a read sampled on that edge sees it.
    always_ff @(posedge hclk) begin
        if (state == S_DATA && pending && write_q) begin
            for (int i = 0; i < BYTES; i++) begin
                if (lane_en[i]) mem[idx_q][8*i +: 8] <= bus.hwdata[8*i +: 8];
            end
        end
    end

    assign bus.hreadyout = (state != S_WAIT) && (state != S_ERR1);
    assign bus.hresp     = (state == S_ERR1) || (state == S_ERR2);
    assign bus.hrdata    = (state == S_DATA && !write_q) ? mem[idx_q] : '0;
endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// tb/tb_ahb_lite_slave_mem.sv - randomized bench for ahb_lite_slave_mem with WAIT_STATES 0, 3 and 2
module tb_ahb_lite_slave_mem;
    logic        hclk = 1'b0;
    logic        hresetn;
    logic        d_sel;
    logic [31:0] d_addr;
    logic [1:0]  d_trans;
    logic        d_write;
    logic [2:0]  d_size;
    logic [31:0] d_wdata;
    logic        stall;
    int          act;

    logic [2:0]  rdy_v;
    logic [2:0]  resp_v;
    logic [31:0] rdata_v [3];

    logic [31:0] model [3][256];
    int          ws_tab [3] = '{0, 3, 2};
    int          total = 0;
    int          bad = 0;

    always #5 hclk = ~hclk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        ahb_lite_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
        assign bus.hsel    = d_sel && (act == g);
        assign bus.haddr   = d_addr;
        assign bus.htrans  = (act == g) ? d_trans : 2'b00;
        assign bus.hwrite  = d_write;
        assign bus.hsize   = d_size;
        assign bus.hburst  = 3'b000;
        assign bus.hprot   = 4'b0011;
        assign bus.hready  = bus.hreadyout && !stall;
        assign bus.hwdata  = d_wdata;
        assign rdy_v[g]    = bus.hreadyout;
        assign resp_v[g]   = bus.hresp;
        assign rdata_v[g]  = bus.hrdata;
        ahb_lite_slave_mem #(.WAIT_STATES(g == 0 ? 0 : (g == 1 ? 3 : 2))) dut (
            .hclk(hclk), .hresetn(hresetn), .bus(bus)
        );
    end

    // Memory seen as bytes: a transfer moves 2^size bytes starting at addr, little-endian lanes.
    function automatic void model_xfer(input int k, input bit wr, input logic [31:0] addr,
                                       input logic [2:0] size, input logic [31:0] wdata,
                                       output bit err, output logic [31:0] rd);
        int nb = 1 << size;
        err = (addr >= 32'h400) || (nb > 4) || ((int'(addr[1:0]) % nb) != 0);
        rd = '0;
        if (!err) begin
            if (wr) begin
                for (int b = 0; b < nb; b++) begin
                    int lane = int'(addr[1:0]) + b;
                    model[k][addr[9:2]][8*lane +: 8] = wdata[8*lane +: 8];
                end
            end else begin
                rd = model[k][addr[9:2]];
            end
        end
    endfunction

    task automatic xfer(input int k, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, output int n_low, output int n_low_resp,
                        output logic [31:0] low_rdata, output logic fresp, output logic [31:0] frdata);
        act = k; d_sel = 1'b1; d_trans = 2'b10; d_write = wr; d_addr = addr; d_size = size;
        @(posedge hclk);
        @(negedge hclk);
        d_sel = 1'b0; d_trans = 2'b00; d_wdata = wdata;
        n_low = 0; n_low_resp = 0; low_rdata = '0;
        while (rdy_v[k] !== 1'b1 && n_low < 40) begin
            if (resp_v[k] === 1'b1) n_low_resp++;
            low_rdata |= rdata_v[k];
            n_low++;
            @(negedge hclk);
        end
        fresp = resp_v[k];
        frdata = rdata_v[k];
    endtask

    task automatic test_reset();
        hresetn = 1'b0; act = 0; stall = 1'b0;
        d_sel = 1'b1; d_trans = 2'b10; d_write = 1'b1; d_addr = 32'h10; d_size = 3'd2; d_wdata = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge hclk);
            for (int k = 0; k < 3; k++) begin
                total++;
                if ({rdy_v[k], resp_v[k], rdata_v[k]} !== {1'b1, 1'b0, 32'h0}) begin
                    bad++;
                    $display("FAIL reset[%0d] cycle %0d: rdy=%b resp=%b rdata=%h want rdy=1 resp=0 rdata=0",
                             k, c, rdy_v[k], resp_v[k], rdata_v[k]);
                end
            end
        end
        d_sel = 1'b0; d_trans = 2'b00; hresetn = 1'b1;
    endtask

    task automatic test_init();
        int n, nr; logic [31:0] lr, rd, exp, data; logic fr; bit err;
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 64; w++) begin
                data = $urandom;
                xfer(k, 1'b1, 32'(w * 4), 3'd2, data, n, nr, lr, fr, rd);
                model_xfer(k, 1'b1, 32'(w * 4), 3'd2, data, err, exp);
                total++;
                if (n !== ws_tab[k] || nr !== 0 || fr !== 1'b0) begin
                    bad++;
                    $display("FAIL init[%0d] word %0d: waits=%0d resp=%b want waits=%0d resp=0", k, w, n, fr, ws_tab[k]);
                end
            end
        end
    endtask

    task automatic test_word_rw();
        int n, nr; logic [31:0] lr, rd, exp; logic fr; bit err;
        xfer(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, n, nr, lr, fr, rd);
        model_xfer(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, err, exp);
        total++;
        if (n !== 0 || fr !== 1'b0) begin
            bad++; $display("FAIL word_write: waits=%0d resp=%b want 0 0", n, fr);
        end
        xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, n, nr, lr, fr, rd);
        total++;
        if (n !== 0 || rd !== 32'hDEADBEEF) begin
            bad++; $display("FAIL word_read: waits=%0d rdata=%h want 0 deadbeef", n, rd);
        end
    endtask

    task automatic test_byte_lanes();
        int n, nr; logic [31:0] lr, rd, exp; logic fr; bit err;
        xfer(0, 1'b1, 32'h20, 3'd2, 32'h11223344, n, nr, lr, fr, rd);
        model_xfer(0, 1'b1, 32'h20, 3'd2, 32'h11223344, err, exp);
        xfer(0, 1'b1, 32'h21, 3'd0, 32'h0000AA00, n, nr, lr, fr, rd);
        model_xfer(0, 1'b1, 32'h21, 3'd0, 32'h0000AA00, err, exp);
        xfer(0, 1'b0, 32'h20, 3'd2, 32'h0, n, nr, lr, fr, rd);
        total++;
        if (rd !== 32'h1122AA44) begin
            bad++; $display("FAIL byte_lanes: rdata=%h want 1122aa44", rd);
        end
    endtask

    task automatic test_wait_states();
        int n, nr; logic [31:0] lr, rd, exp; logic fr; bit err;
        xfer(1, 1'b0, 32'h14, 3'd2, 32'h0, n, nr, lr, fr, rd);
        model_xfer(1, 1'b0, 32'h14, 3'd2, 32'h0, err, exp);
        total++;
        if (n !== 3 || nr !== 0 || lr !== 32'h0 || fr !== 1'b0) begin
            bad++; $display("FAIL wait3_timing: waits=%0d resp_low=%0d rdata_low=%h resp=%b want 3 0 0 0", n, nr, lr, fr);
        end
        total++;
        if (rd !== exp) begin
            bad++; $display("FAIL wait3_rdata: rdata=%h want %h", rd, exp);
        end
    endtask

    task automatic test_error();
        int n, nr; logic [31:0] lr, rd, exp; logic fr; bit err;
        for (int k = 0; k < 2; k++) begin
            xfer(k, 1'b0, 32'h400, 3'd2, 32'h0, n, nr, lr, fr, rd);
            total++;
            if (n !== 1 || nr !== 1 || fr !== 1'b1 || rd !== 32'h0 || lr !== 32'h0) begin
                bad++; $display("FAIL err_range[%0d]: low=%0d resp_low=%0d resp=%b rdata=%h want 1 1 1 0", k, n, nr, fr, rd);
            end
            xfer(k, 1'b1, 32'h3, 3'd1, 32'hFFFFFFFF, n, nr, lr, fr, rd);
            total++;
            if (n !== 1 || nr !== 1 || fr !== 1'b1 || rd !== 32'h0) begin
                bad++; $display("FAIL err_align[%0d]: low=%0d resp_low=%0d resp=%b rdata=%h want 1 1 1 0", k, n, nr, fr, rd);
            end
            xfer(k, 1'b0, 32'h0, 3'd2, 32'h0, n, nr, lr, fr, rd);
            model_xfer(k, 1'b0, 32'h0, 3'd2, 32'h0, err, exp);
            total++;
            if (rd !== exp || fr !== 1'b0) begin
                bad++; $display("FAIL err_mem_kept[%0d]: rdata=%h resp=%b want %h 0", k, rd, fr, exp);
            end
        end
        xfer(0, 1'b1, 32'h3FC, 3'd2, 32'hA5A5_0FF0, n, nr, lr, fr, rd);
        model_xfer(0, 1'b1, 32'h3FC, 3'd2, 32'hA5A5_0FF0, err, exp);
        xfer(0, 1'b0, 32'h3FC, 3'd2, 32'h0, n, nr, lr, fr, rd);
        total++;
        if (fr !== 1'b0 || rd !== 32'hA5A5_0FF0) begin
            bad++; $display("FAIL last_word: resp=%b rdata=%h want 0 a5a50ff0", fr, rd);
        end
    endtask

    task automatic test_hready_stall();
        int n, nr; logic [31:0] lr, rd, exp; logic fr; bit err;
        @(negedge hclk);
        act = 1; stall = 1'b1; d_wdata = 32'hFFFFFFFF;
        d_sel = 1'b1; d_trans = 2'b10; d_write = 1'b1; d_addr = 32'h8; d_size = 3'd2;
        @(posedge hclk);
        @(negedge hclk);
        d_sel = 1'b0; d_trans = 2'b00;
        total++;
        if (rdy_v[1] !== 1'b1) begin
            bad++; $display("FAIL stall_no_sample: hreadyout=%b want 1", rdy_v[1]);
        end
        stall = 1'b0;
        @(negedge hclk);
        xfer(1, 1'b0, 32'h8, 3'd2, 32'h0, n, nr, lr, fr, rd);
        model_xfer(1, 1'b0, 32'h8, 3'd2, 32'h0, err, exp);
        total++;
        if (rd !== exp) begin
            bad++; $display("FAIL stall_mem_kept: rdata=%h want %h", rd, exp);
        end
    endtask

    task automatic test_reset_mid_write();
        int n, nr; logic [31:0] lr, rd, exp; logic fr; bit err;
        @(negedge hclk);
        act = 2; d_sel = 1'b1; d_trans = 2'b10; d_write = 1'b1; d_addr = 32'h30; d_size = 3'd2;
        @(posedge hclk);
        @(negedge hclk);
        d_sel = 1'b0; d_trans = 2'b00; d_wdata = 32'h55;
        total++;
        if (rdy_v[2] !== 1'b0) begin
            bad++; $display("FAIL midwrite_wait: hreadyout=%b want 0", rdy_v[2]);
        end
        hresetn = 1'b0;
        #1;
        total++;
        if ({rdy_v[2], resp_v[2]} !== 2'b10) begin
            bad++; $display("FAIL midwrite_async: rdy=%b resp=%b want 1 0", rdy_v[2], resp_v[2]);
        end
        @(posedge hclk);
        @(negedge hclk);
        hresetn = 1'b1;
        xfer(2, 1'b0, 32'h30, 3'd2, 32'h0, n, nr, lr, fr, rd);
        model_xfer(2, 1'b0, 32'h30, 3'd2, 32'h0, err, exp);
        total++;
        if (rd !== exp || n !== 2) begin
            bad++; $display("FAIL midwrite_dropped: rdata=%h waits=%0d want %h 2", rd, n, exp);
        end
    endtask

    task automatic test_random();
        int n, nr, k, sel; logic [31:0] lr, rd, exp, addr, data; logic fr; logic [2:0] size; bit err, wr;
        for (int i = 0; i < 180; i++) begin
            k = int'($urandom % 3); wr = 1'($urandom % 2); sel = int'($urandom % 8); data = $urandom;
            if (sel < 6) begin
                size = 3'($urandom % 3);
                addr = 32'(($urandom % 64) * 4 + (($urandom % 4) & ~((32'd1 << size) - 32'd1)));
            end else if (sel == 6) begin
                size = 3'($urandom % 4);
                addr = 32'(($urandom % 64) * 4 + ($urandom % 4));
            end else begin
                size = 3'd2;
                addr = 32'(32'h400 + ($urandom % 1024) * 4);
            end
            if ($urandom % 4 == 0) @(negedge hclk);
            xfer(k, wr, addr, size, data, n, nr, lr, fr, rd);
            model_xfer(k, wr, addr, size, data, err, exp);
            total++;
            if (err ? (n !== 1 || nr !== 1 || fr !== 1'b1) : (n !== ws_tab[k] || nr !== 0 || fr !== 1'b0)) begin
                bad++;
                $display("FAIL rand_resp #%0d inst%0d addr=%h size=%0d: low=%0d resp_low=%0d resp=%b want err=%0b waits=%0d",
                         i, k, addr, size, n, nr, fr, err, err ? 1 : ws_tab[k]);
            end
            total++;
            if (lr !== 32'h0) begin
                bad++; $display("FAIL rand_low_rdata #%0d: rdata=%h want 0", i, lr);
            end
            if (!wr || err) begin
                total++;
                if (rd !== exp) begin
                    bad++; $display("FAIL rand_rdata #%0d inst%0d addr=%h: rdata=%h want %h", i, k, addr, rd, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_word_rw();
        test_byte_lanes();
        test_wait_states();
        test_error();
        test_hready_stall();
        test_reset_mid_write();
        test_random();
        @(negedge hclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ahb_lite_slave_mem.md
# ahb_lite_slave_mem

Parametrised AHB-lite slave memory model for the AHB_lite verification environment: it responds to the master signals carried on the AHB-lite bus interface (hsel, haddr, htrans, hwrite, hsize, hburst, hwdata) and returns hrdata, hreadyout and hresp. It adds three behaviours to the plain bus connection:
- configurable data and address widths;
- a fixed, programmable number of wait states per transfer;
- the two-cycle ERROR response.

It is used as the reference slave behind the driver/monitor pair, and as a standalone DUT for protocol checks.

## Interface
- ADDR_WIDTH, 32, haddr width
- DATA_WIDTH, 32, hwdata/hrdata width; one of 32 or 64
- MEM_DEPTH, 256, storage depth in DATA_WIDTH words; power of two
- WAIT_STATES, 0, hreadyout-low cycles inserted per OKAY transfer; range 0..15
- hclk  input  1  bus clock; all state changes on its rising edge
- hresetn  input  1  reset, asynchronous, active-low
- hsel  input  1  slave select
- haddr  input  ADDR_WIDTH  byte address
- htrans  input  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
- hwrite  input  1  1 = write
- hsize  input  3  transfer size, bytes = 2^hsize
- hburst  input  3  burst type; accepted, ignored
- hprot  input  4  protection; accepted, ignored
- hready  input  1  bus-level ready (tie to hreadyout when single slave)
- hwdata  input  DATA_WIDTH  write data, data phase
- hrdata  output  DATA_WIDTH  read data
- hreadyout  output  1  slave ready
- hresp  output  1  0 OKAY, 1 ERROR

## Operation

**Address phase**
- Sampled on a rising edge with hsel=1, hready=1 and htrans[1]=1 (NONSEQ or SEQ).
- On sampling, register haddr, hwrite and hsize, and set the pending flag.
- IDLE, BUSY and unselected cycles give a zero-wait OKAY.

**Error check** (evaluated at the address phase):
- word index haddr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)] >= MEM_DEPTH;
- 2^hsize > DATA_WIDTH/8;
- haddr not aligned to hsize.

**FSM**
- IDLE: hreadyout=1, hresp=0.
  - On sampled error → ERR1.
  - On sampled good transfer with WAIT_STATES>0 → WAIT, load the counter with WAIT_STATES-1.
  - On sampled good transfer with WAIT_STATES=0 → DATA.
- WAIT: hreadyout=0, hresp=0. Counter decrements each cycle; at 0 → DATA.
- DATA: hreadyout=1, hresp=0. Completes the transfer.
  - A new transfer sampled in the same cycle re-enters WAIT, ERR1 or DATA per the rules above.
  - Otherwise → IDLE.
- ERR1: hreadyout=0, hresp=1 → ERR2.
- ERR2: hreadyout=1, hresp=1. Next state follows the IDLE rules, so a new transfer may be sampled here.

**Data path**
- Write: in the DATA cycle, write only the byte lanes selected by hsize and the registered haddr low bits (little-endian) from hwdata. Other lanes are unchanged.
- Read: in the DATA cycle, hrdata = full memory word. Otherwise hrdata = 0.
- ERROR transfers never modify memory. hrdata = 0 during ERR1 and ERR2.
- Memory contents are not reset.

**Boundary cases**
- Read immediately after a write to the same word returns the new data, because the write commits at the edge that ends its DATA cycle.
- Reset mid-transfer: the pending write is dropped and no memory write occurs.
- hready=0 (another slave stalling) blocks address sampling.

## Timing
- Reset values: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, pending=0, counter=0. All apply asynchronously on hresetn=0.
- With the address phase sampled at edge E0 and W = WAIT_STATES:
  - hreadyout is low in the W cycles after E0;
  - the DATA cycle is cycle W+1;
  - the master samples hrdata and hresp at edge E0+W+1.
- Zero-wait back-to-back transfers sustain one transfer per cycle.
- ERROR: hresp=1 for exactly 2 cycles; hreadyout=0 in the first and 1 in the second.
- All outputs are registered or decoded from FSM state. There is no combinational path from inputs to hreadyout or hresp.

## Test plan
- Reset: hresetn=0 for 3 cycles, with hsel=1 and NONSEQ held → hreadyout=1, hresp=0, hrdata=0 throughout.
- Word write/read, WAIT_STATES=0: write 0xDEADBEEF to 0x10, then read 0x10 back-to-back → hrdata=0xDEADBEEF one cycle after the read address phase, no wait cycles.
- Byte lanes: write word 0x11223344 to 0x20, then byte 0xAA with hsize=0 at 0x21 → read 0x20 returns 0x1122AA44.
- Wait states, WAIT_STATES=3: read transfer → hreadyout low for exactly 3 cycles, data on the 4th cycle after the address edge.
- Error: read 0x400 (word index 256 with MEM_DEPTH=256), then misaligned halfword at 0x3 → each gives hreadyout 0→1 with hresp=1 for 2 cycles; memory unchanged.
- Reset mid-write: write 0x55 to 0x30 with WAIT_STATES=2 and assert hresetn=0 during WAIT → a later read of 0x30 returns the old value.
